// File: rtl/ahbl_to_apb_bridge_pkg.sv
// Bus-fabric encodings shared by the AHB-Lite to APB bridge.
// HTRANS/HSIZE codes and the bridge FSM state type.
package ahbl_to_apb_bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WCAP   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_ACCESS = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } state_t;

   // NONSEQ and SEQ both carry bit 1
   function automatic logic htrans_active(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

// File: rtl/ahbl_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge, one word per APB transfer.
// All outputs are registered; sidebands ride along with the address.
module ahbl_to_apb_bridge
   import ahbl_to_apb_bridge_pkg::*;
#(
   parameter int W_HADDR = 32,
   parameter int W_PADDR = 16,
   parameter int W_DATA  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ahbls_hready,
   output logic               ahbls_hready_resp,
   output logic               ahbls_hresp,
   input  logic [W_HADDR-1:0] ahbls_haddr,
   input  logic               ahbls_hwrite,
   input  logic [1:0]         ahbls_htrans,
   input  logic [2:0]         ahbls_hsize,
   input  logic [W_DATA-1:0]  ahbls_hwdata,
   output logic [W_DATA-1:0]  ahbls_hrdata,
   input  logic [W_DATA-1:0]  ahbls_hartid,
   input  logic [31:0]        ahbls_pd_pc,
   output logic [W_PADDR-1:0] apbm_paddr,
   output logic               apbm_psel,
   output logic               apbm_penable,
   output logic               apbm_pwrite,
   output logic [W_DATA-1:0]  apbm_pwdata,
   input  logic               apbm_pready,
   input  logic [W_DATA-1:0]  apbm_prdata,
   input  logic               apbm_pslverr,
   output logic [W_DATA-1:0]  apbm_phartid,
   output logic [31:0]        apbm_pd_pc
);

   state_t state;
   logic   can_accept;
   logic   take;
   logic   unused;

   // only the low address bits reach APB; SEQ vs NONSEQ is irrelevant
   assign unused = ^{ahbls_htrans[0], ahbls_haddr[W_HADDR-1:W_PADDR]};

   assign can_accept = (state == ST_IDLE) || (state == ST_ERR2);
   assign take = can_accept && ahbls_hready
               && htrans_active(ahbls_htrans);

   // bridge FSM with registered AHB response and APB request outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= ST_IDLE;
         ahbls_hready_resp <= 1'b1;
         ahbls_hresp       <= 1'b0;
         ahbls_hrdata      <= '0;
         apbm_paddr        <= '0;
         apbm_psel         <= 1'b0;
         apbm_penable      <= 1'b0;
         apbm_pwrite       <= 1'b0;
         apbm_pwdata       <= '0;
         apbm_phartid      <= '0;
         apbm_pd_pc        <= '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_ERR2: begin
               if (take) begin
                  apbm_paddr        <= ahbls_haddr[W_PADDR-1:0];
                  apbm_pwrite       <= ahbls_hwrite;
                  apbm_phartid      <= ahbls_hartid;
                  apbm_pd_pc        <= ahbls_pd_pc;
                  ahbls_hready_resp <= 1'b0;
                  if (ahbls_hsize != HSIZE_WORD) begin
                     ahbls_hresp <= 1'b1;
                     state       <= ST_ERR1;
                  end else if (ahbls_hwrite) begin
                     ahbls_hresp <= 1'b0;
                     state       <= ST_WCAP;
                  end else begin
                     ahbls_hresp <= 1'b0;
                     apbm_psel   <= 1'b1;
                     state       <= ST_SETUP;
                  end
               end else begin
                  ahbls_hready_resp <= 1'b1;
                  ahbls_hresp       <= 1'b0;
                  state             <= ST_IDLE;
               end
            end
            ST_WCAP: begin
               apbm_pwdata <= ahbls_hwdata;
               apbm_psel   <= 1'b1;
               state       <= ST_SETUP;
            end
            ST_SETUP: begin
               apbm_penable <= 1'b1;
               state        <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (apbm_pready) begin
                  apbm_psel    <= 1'b0;
                  apbm_penable <= 1'b0;
                  if (apbm_pslverr) begin
                     ahbls_hresp <= 1'b1;
                     state       <= ST_ERR1;
                  end else begin
                     ahbls_hready_resp <= 1'b1;
                     if (!apbm_pwrite) begin
                        ahbls_hrdata <= apbm_prdata;
                     end
                     state <= ST_IDLE;
                  end
               end
            end
            ST_ERR1: begin
               ahbls_hready_resp <= 1'b1;
               state             <= ST_ERR2;
            end
            default: begin
               ahbls_hready_resp <= 1'b1;
               ahbls_hresp       <= 1'b0;
               apbm_psel         <= 1'b0;
               apbm_penable      <= 1'b0;
               state             <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// Bench for the AHB-Lite to APB bridge: directed scenarios, then
// random transfers against a word-memory reference model.
module tb_ahbl_to_apb_bridge;

   logic        clk;
   logic        rst_n;
   logic        hready;
   logic        hready_resp;
   logic        hresp;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic [31:0] hartid;
   logic [31:0] pd_pc;
   logic [15:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;
   logic [31:0] phartid;
   logic [31:0] p_pd_pc;

   int tests;
   int fails;

   int slv_wait;
   bit slv_err;

   logic [31:0] smem [logic [15:0]];
   logic [31:0] ref_mem [logic [15:0]];
   logic [31:0] exp_hrdata;

   ahbl_to_apb_bridge dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ahbls_hready      (hready),
      .ahbls_hready_resp (hready_resp),
      .ahbls_hresp       (hresp),
      .ahbls_haddr       (haddr),
      .ahbls_hwrite      (hwrite),
      .ahbls_htrans      (htrans),
      .ahbls_hsize       (hsize),
      .ahbls_hwdata      (hwdata),
      .ahbls_hrdata      (hrdata),
      .ahbls_hartid      (hartid),
      .ahbls_pd_pc       (pd_pc),
      .apbm_paddr        (paddr),
      .apbm_psel         (psel),
      .apbm_penable      (penable),
      .apbm_pwrite       (pwrite),
      .apbm_pwdata       (pwdata),
      .apbm_pready       (pready),
      .apbm_prdata       (prdata),
      .apbm_pslverr      (pslverr),
      .apbm_phartid      (phartid),
      .apbm_pd_pc        (p_pd_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] dflt(input logic [15:0] a);
      return {16'hC0DE, a};
   endfunction

   // APB slave: word memory, programmable wait states and error
   initial begin : apb_slave
      int cnt;
      cnt     = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            cnt     = 0;
            pready  = 1'b0;
            pslverr = 1'b0;
         end else if (psel && penable) begin
            if (cnt > 0) begin
               cnt--;
               pready  = 1'b0;
               pslverr = 1'($urandom);
               prdata  = $urandom;
            end else begin
               pready  = 1'b1;
               pslverr = slv_err;
               if (slv_err) begin
                  prdata = $urandom;
               end else begin
                  prdata = smem.exists(paddr) ? smem[paddr] : dflt(paddr);
                  if (pwrite) smem[paddr] = pwdata;
               end
            end
         end else begin
            if (psel) cnt = slv_wait;
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic string tg(input string n, input int k);
      return $sformatf("%s@A+%0d", n, k);
   endfunction

   // one AHB transfer whose address phase is the current cycle
   task automatic xfer(input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] size,
                       input int waits, input bit err,
                       input logic [31:0] hid, input logic [31:0] pc);
      logic [15:0] pa;
      bit          bad;
      int          s;
      int          c;
      int          last;
      logic        e_psel, e_pen, e_rdy, e_resp;
      pa  = addr[15:0];
      bad = (size != 3'd2);
      s   = wr ? 2 : 1;
      c   = s + waits + 2;
      last = bad ? 2 : (err ? c + 1 : c);
      if (!bad && !err) begin
         if (wr) ref_mem[pa] = wd;
         else exp_hrdata = ref_mem.exists(pa) ? ref_mem[pa] : dflt(pa);
      end
      hready   = 1'b1;
      htrans   = 2'b10;
      haddr    = addr;
      hwrite   = wr;
      hsize    = size;
      hartid   = hid;
      pd_pc    = pc;
      hwdata   = ~wd;
      slv_wait = waits;
      slv_err  = err;
      for (int k = 1; k <= last; k++) begin
         step();
         if (k == 1) begin
            htrans = 2'b00;
            haddr  = $urandom;
            hwrite = 1'($urandom);
            hsize  = 3'($urandom);
            hartid = $urandom;
            pd_pc  = $urandom;
            hwdata = wr ? wd : $urandom;
         end else begin
            hwdata = $urandom;
         end
         e_psel = 1'b0;
         e_pen  = 1'b0;
         e_rdy  = 1'b0;
         e_resp = 1'b0;
         if (bad) begin
            e_resp = 1'b1;
            e_rdy  = (k == 2);
         end else if (k < s) begin
            e_rdy = 1'b0;
         end else if (k < c) begin
            e_psel = 1'b1;
            e_pen  = (k > s);
         end else if (!err) begin
            e_rdy = 1'b1;
         end else begin
            e_resp = 1'b1;
            e_rdy  = (k == c + 1);
         end
         chk(tg("psel", k), psel, e_psel);
         chk(tg("penable", k), penable, e_pen);
         chk(tg("hready_resp", k), hready_resp, e_rdy);
         chk(tg("hresp", k), hresp, e_resp);
         if (e_psel) begin
            chk(tg("paddr", k), paddr, pa);
            chk(tg("pwrite", k), pwrite, wr);
            chk(tg("phartid", k), phartid, hid);
            chk(tg("pd_pc", k), p_pd_pc, pc);
            if (wr) chk(tg("pwdata", k), pwdata, wd);
         end
         if (k == last) chk(tg("hrdata", k), hrdata, exp_hrdata);
      end
   endtask

   task automatic idle_chk(input string n);
      htrans = 2'b00;
      step();
      chk({n, " idle hready_resp"}, hready_resp, 1'b1);
      chk({n, " idle hresp"}, hresp, 1'b0);
      chk({n, " idle psel"}, psel, 1'b0);
      chk({n, " idle penable"}, penable, 1'b0);
   endtask

   initial begin : main
      logic [15:0] addrs [4];
      tests      = 0;
      fails      = 0;
      rst_n      = 1'b0;
      hready     = 1'b0;
      htrans     = 2'b00;
      haddr      = '0;
      hwrite     = 1'b0;
      hsize      = 3'd0;
      hwdata     = '0;
      hartid     = '0;
      pd_pc      = '0;
      slv_wait   = 0;
      slv_err    = 1'b0;
      exp_hrdata = '0;
      addrs[0] = 16'h0010;
      addrs[1] = 16'h0014;
      addrs[2] = 16'h2004;
      addrs[3] = 16'h0080;
      smem[16'h0010]    = 32'hDEADBEEF;
      ref_mem[16'h0010] = 32'hDEADBEEF;

      repeat (2) step();
      chk("rst hready_resp", hready_resp, 1'b1);
      chk("rst hresp", hresp, 1'b0);
      chk("rst hrdata", hrdata, 32'h0);
      chk("rst psel", psel, 1'b0);
      chk("rst penable", penable, 1'b0);
      chk("rst paddr", paddr, 16'h0);
      chk("rst pwrite", pwrite, 1'b0);
      chk("rst pwdata", pwdata, 32'h0);
      chk("rst phartid", phartid, 32'h0);
      chk("rst pd_pc", p_pd_pc, 32'h0);
      rst_n = 1'b1;
      step();

      xfer(1'b0, 32'h4000_0010, 32'h0, 3'd2, 0, 1'b0,
           32'h3, 32'h8000_0000);
      idle_chk("rd");

      xfer(1'b1, 32'h0000_2004, 32'h1234_5678, 3'd2, 2, 1'b0,
           32'h7, 32'h8000_0040);
      idle_chk("wr");

      xfer(1'b0, 32'h4000_0010, 32'h0, 3'd2, 0, 1'b1,
           32'h5, 32'h8000_0080);
      idle_chk("rderr");

      xfer(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 3'd1, 0, 1'b0,
           32'h6, 32'h8000_00C0);
      idle_chk("badsz");

      xfer(1'b1, 32'h0000_2004, 32'hA5A5_0001, 3'd2, 0, 1'b0,
           32'h1, 32'h8000_0100);
      xfer(1'b0, 32'h0000_2004, 32'h0, 3'd2, 1, 1'b0,
           32'h2, 32'h8000_0104);
      idle_chk("b2b");

      hready = 1'b0;
      htrans = 2'b10;
      hsize  = 3'd2;
      step();
      chk("nohready psel", psel, 1'b0);
      chk("nohready hready_resp", hready_resp, 1'b1);
      hready = 1'b1;
      htrans = 2'b01;
      step();
      chk("busy psel", psel, 1'b0);
      chk("busy hready_resp", hready_resp, 1'b1);
      idle_chk("busy");

      hready   = 1'b1;
      htrans   = 2'b10;
      haddr    = 32'h4000_0014;
      hwrite   = 1'b0;
      hsize    = 3'd2;
      hartid   = 32'h9;
      pd_pc    = 32'h8000_0200;
      slv_wait = 6;
      slv_err  = 1'b0;
      step();
      htrans = 2'b00;
      step();
      chk("midrst pre penable", penable, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst psel", psel, 1'b0);
      chk("midrst penable", penable, 1'b0);
      chk("midrst paddr", paddr, 16'h0);
      chk("midrst hready_resp", hready_resp, 1'b1);
      chk("midrst hresp", hresp, 1'b0);
      chk("midrst phartid", phartid, 32'h0);
      chk("midrst hrdata", hrdata, 32'h0);
      exp_hrdata = '0;
      step();
      rst_n = 1'b1;
      step();
      xfer(1'b0, 32'h4000_0010, 32'h0, 3'd2, 0, 1'b0,
           32'h3, 32'h8000_0000);
      idle_chk("postrst");

      for (int i = 0; i < 40; i++) begin
         bit          wr;
         bit          er;
         logic [2:0]  sz;
         logic [31:0] a;
         wr = 1'($urandom);
         er = ($urandom_range(0, 5) == 0);
         sz = 3'd2;
         if ($urandom_range(0, 7) == 0) begin
            sz = 3'($urandom);
            if (sz == 3'd2) sz = 3'd1;
         end
         a = {16'($urandom), addrs[$urandom_range(0, 3)]};
         xfer(wr, a, $urandom, sz, $urandom_range(0, 3), er,
              $urandom, $urandom);
         if ($urandom_range(0, 1) == 0) idle_chk("rnd");
      end
      idle_chk("end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ahbl_to_apb_bridge.md
Name: ahbl_to_apb_bridge

Overview:
AHB-Lite slave to APB master bridge. It sits upstream of the APB splitter and is the single initiator driving its slave-side APB port. It converts each accepted AHB-Lite word transfer into one APB SETUP/ACCESS sequence and returns the data or error to AHB. It also carries the hart ID and debug-PC sidebands through to APB.

Parameters:
W_HADDR, 32, AHB address width
W_PADDR, 16, APB address width; paddr = haddr[W_PADDR-1:0]
W_DATA, 32, data width for both buses; only 32 is supported

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
ahbls_hready  in  1  bus-wide hready; an address phase is sampled when this is high
ahbls_hready_resp  out  1  this slave's hready
ahbls_hresp  out  1  error response
ahbls_haddr  in  W_HADDR  address
ahbls_hwrite  in  1  write
ahbls_htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ
ahbls_hsize  in  3  transfer size
ahbls_hwdata  in  W_DATA  write data
ahbls_hrdata  out  W_DATA  read data
ahbls_hartid  in  W_DATA  hart ID sideband, sampled in the address phase
ahbls_pd_pc  in  32  debug PC sideband, sampled in the address phase
apbm_paddr  out  W_PADDR  APB address
apbm_psel  out  1  APB select
apbm_penable  out  1  APB enable
apbm_pwrite  out  1  APB write
apbm_pwdata  out  W_DATA  APB write data
apbm_pready  in  1  APB ready
apbm_prdata  in  W_DATA  APB read data
apbm_pslverr  in  1  APB slave error
apbm_phartid  out  W_DATA  hart ID, held for the whole APB transfer
apbm_pd_pc  out  32  debug PC, held for the whole APB transfer

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - ahbls_hready_resp = 1, ahbls_hresp = 0, ahbls_hrdata = 0.
  - All apbm_* outputs = 0.
  - State = IDLE.
- Every output is registered; there are no combinational paths from inputs to outputs.
- Accept condition: ahbls_hready & ahbls_htrans[1], sampled only in IDLE or ERR2.
  - On accept, latch haddr[W_PADDR-1:0], hwrite, hartid and pd_pc.
  - On accept, hready_resp goes to 0 next cycle (except the bad-size path, where it is already 0 via ERR1).
- Bad size: if hsize != 3'd2 on accept, go to ERR1. No APB activity occurs.
- States:
  - IDLE: hready_resp=1, hresp=0.
    - Accepted read -> SETUP.
    - Accepted write -> WCAP.
    - Bad size -> ERR1.
  - WCAP: latch ahbls_hwdata into apbm_pwdata -> SETUP.
  - SETUP: psel=1, penable=0; paddr, pwrite, pwdata and sidebands stable -> ACCESS.
  - ACCESS: psel=1, penable=1; hold until pready.
    - pready & !pslverr: hrdata <= prdata on reads (on writes hrdata is unchanged); psel and penable <= 0; hready_resp <= 1; -> IDLE.
    - pready & pslverr: psel and penable <= 0 -> ERR1.
  - ERR1: hresp=1, hready_resp=0 -> ERR2.
  - ERR2: hresp=1, hready_resp=1. Accept is legal this cycle (same rules as IDLE), otherwise -> IDLE.
- Latency, address-phase cycle = A, zero APB wait states:
  - Read: SETUP at A+1, ACCESS at A+2, hready_resp=1 with hrdata valid at A+3.
  - Write: WCAP A+1, SETUP A+2, ACCESS A+3, completion A+4.
  - Each APB wait state adds one cycle.
- No idle cycle is needed between transfers: a transfer accepted in the completion cycle goes straight to SETUP or WCAP.
- paddr, pwrite, pwdata and both sidebands hold from SETUP until the end of ACCESS; psel is not deasserted before pready.
- htrans IDLE/BUSY or hready=0 in IDLE: no action.
- Reset mid-transfer (any state): all outputs return to reset values immediately, even with pready pending. Any in-flight APB transfer is abandoned; the APB slave sees psel drop.
- pready and pslverr are ignored outside ACCESS.

Decomposition:
- Shared busfabric package:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE_WORD = 3'd2.
  - State encoding localparams: IDLE, WCAP, SETUP, ACCESS, ERR1, ERR2, one-hot or 3-bit binary.
- No sub-module; a single FSM plus its capture registers.

Test Plan:
- Read, haddr=0x4000_0010, slave returns prdata=0xDEADBEEF with pready=1 immediately -> paddr=0x0010 and psel=1 at A+1, penable=1 at A+2, hready_resp=1 and hrdata=0xDEADBEEF at A+3, hresp=0 throughout.
- Write 0x1234_5678 to 0x2004, pready held low 2 cycles -> pwdata=0x12345678 and pwrite=1 from A+2; ACCESS lasts 3 cycles; hready_resp returns at A+6; paddr, pwdata and sidebands stable throughout.
- Read with pslverr=1, pready=1 -> hresp=1/hready_resp=0 for one cycle, then hresp=1/hready_resp=1 for one cycle, then IDLE; hrdata unchanged.
- hsize=3'd1 write -> no psel ever asserted; two-cycle error response starting the cycle after accept.
- Back-to-back write then read, with htrans=NONSEQ held in the completion cycle -> read SETUP immediately in the cycle after the write completes; hartid=0x1 and pd_pc=0x8000_0100 captured per transfer appear on apbm_phartid/apbm_pd_pc.
- rst_n low during ACCESS with pready=0 -> psel, penable and paddr are 0 and hready_resp=1 in the same cycle; the next read after release behaves as in the first scenario.
